// File: rtl/piso_tx_shifter.sv
// piso_tx_shifter: parallel-in, serial-out transmitter.
// A word is taken in over a valid/ready handshake into a one-deep holding
// buffer and then sent LSB-first on sout. The sen strobe marks every cycle
// that carries a bit, so it can drive a receiving shift register's mode
// select directly. An optional GAP of idle cycles separates frames.
module piso_tx_shifter #(
    parameter int WIDTH = 8,
    parameter int GAP   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             sout,
    output logic             sen,
    output logic             frame_done,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

    localparam logic [CW-1:0] CNT_LAST  = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [GW-1:0] GCNT_LAST = GW'((GAP > 0) ? (GAP - 1) : 0);
    localparam logic [GW-1:0] GCNT_ONE  = GW'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_GAP
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] hbuf_q;
    logic             hfull_q;
    logic [WIDTH-1:0] sh_q;
    logic [CW-1:0]    cnt_q;
    logic [GW-1:0]    gcnt_q;

    // Handshake acceptance, frame sequencing and the shift datapath all live
    // in one register block; buffer fill and drain are mutually exclusive
    // because acceptance is only possible while the buffer is empty.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            hbuf_q  <= '0;
            hfull_q <= 1'b0;
            sh_q    <= '0;
            cnt_q   <= '0;
            gcnt_q  <= '0;
        end else begin
            if (load_valid && !hfull_q) begin
                hbuf_q  <= din;
                hfull_q <= 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (hfull_q) begin
                        sh_q    <= hbuf_q;
                        hfull_q <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= ST_SHIFT;
                    end
                end

                ST_SHIFT: begin
                    sh_q  <= sh_q >> 1;
                    cnt_q <= cnt_q + CNT_ONE;
                    if (cnt_q == CNT_LAST) begin
                        if (GAP == 0 && hfull_q) begin
                            sh_q    <= hbuf_q;
                            hfull_q <= 1'b0;
                            cnt_q   <= '0;
                        end else if (GAP > 0) begin
                            gcnt_q  <= '0;
                            state_q <= ST_GAP;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end

                ST_GAP: begin
                    gcnt_q <= gcnt_q + GCNT_ONE;
                    if (gcnt_q == GCNT_LAST) begin
                        if (hfull_q) begin
                            sh_q    <= hbuf_q;
                            hfull_q <= 1'b0;
                            cnt_q   <= '0;
                            state_q <= ST_SHIFT;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Outputs are pure decodes of the registers so nothing combinational
    // leaks from load_valid to load_ready, and reset clears them at once.
    always_comb begin
        load_ready = ~hfull_q;
        sen        = (state_q == ST_SHIFT);
        sout       = (state_q == ST_SHIFT) & sh_q[0];
        frame_done = (state_q == ST_SHIFT) && (cnt_q == CNT_LAST);
        busy       = (state_q != ST_IDLE) || hfull_q;
    end

endmodule

// File: tb/tb_piso_tx_shifter.sv
// Directed testbench for piso_tx_shifter. Two instances are used: one with
// GAP=0 for most scenarios and one with GAP=2 for gap insertion. A small
// receiver model (serial-shift mode, LSB-first) rebuilds each word.
module tb_piso_tx_shifter;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;

    logic [W-1:0] din0;
    logic         valid0;
    logic         ready0, sout0, sen0, fd0, busy0;

    logic [W-1:0] dinG;
    logic         validG;
    logic         readyG, soutG, senG, fdG, busyG;

    logic [W-1:0] po0, poG;

    int checkCount = 0;
    int passCount  = 0;

    // Free-running clock, 10 time units per period
    always #5 clk = ~clk;

    piso_tx_shifter #(.WIDTH(W), .GAP(0)) dut0 (
        .clk        (clk),
        .rst        (rst),
        .din        (din0),
        .load_valid (valid0),
        .load_ready (ready0),
        .sout       (sout0),
        .sen        (sen0),
        .frame_done (fd0),
        .busy       (busy0)
    );

    piso_tx_shifter #(.WIDTH(W), .GAP(2)) dutG (
        .clk        (clk),
        .rst        (rst),
        .din        (dinG),
        .load_valid (validG),
        .load_ready (readyG),
        .sout       (soutG),
        .sen        (senG),
        .frame_done (fdG),
        .busy       (busyG)
    );

    // Receiver model for the GAP=0 instance: shift right with sout entering
    // at the MSB whenever sen is high, so LSB-first data lands in place
    always @(posedge clk or negedge rst) begin
        if (!rst) po0 <= '0;
        else if (sen0) po0 <= {sout0, po0[W-1:1]};
    end

    // Same receiver model for the GAP=2 instance
    always @(posedge clk or negedge rst) begin
        if (!rst) poG <= '0;
        else if (senG) poG <= {soutG, poG[W-1:1]};
    end

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed === expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive the handshake inputs of the GAP=0 instance
    task automatic applyStimulus(input logic [W-1:0] d, input logic v);
        din0   = d;
        valid0 = v;
    endtask

    // Walk through W strobed cycles of the GAP=0 instance, checking each bit
    task automatic checkFrame(input string tag, input logic [W-1:0] word);
        for (int i = 0; i < W; i++) begin
            checkOutput({tag, " sen"}, 32'(sen0), 32'd1);
            checkOutput({tag, " sout"}, 32'(sout0), 32'(word[i]));
            checkOutput({tag, " frame_done"}, 32'(fd0), 32'(i == W - 1));
            tick();
        end
    endtask

    // Safety net so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main directed sequence
    initial begin
        logic [W-1:0] word;
        logic [W-1:0] bpWords [3];
        int           acceptLog [$];
        logic [W-1:0] rxLog [$];
        int           idx;
        int           strobes;
        logic         accepted;
        logic         frameEnd;
        logic         expSen, expSout, expFd;

        rst    = 1'b0;
        din0   = '0;
        valid0 = 1'b0;
        dinG   = '0;
        validG = 1'b0;

        // Reset state
        #12;
        checkOutput("reset sout", 32'(sout0), 32'd0);
        checkOutput("reset sen", 32'(sen0), 32'd0);
        checkOutput("reset frame_done", 32'(fd0), 32'd0);
        checkOutput("reset busy", 32'(busy0), 32'd0);
        checkOutput("reset load_ready", 32'(ready0), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Idle hold for 20 cycles
        for (int c = 0; c < 20; c++) begin
            tick();
            checkOutput("idle sen", 32'(sen0), 32'd0);
            checkOutput("idle sout", 32'(sout0), 32'd0);
            checkOutput("idle busy", 32'(busy0), 32'd0);
            checkOutput("idle load_ready", 32'(ready0), 32'd1);
        end

        // Single word A5: accept edge, transfer edge, then 8 strobed bits
        applyStimulus(8'hA5, 1'b1);
        tick();
        applyStimulus('0, 1'b0);
        checkOutput("single ready after accept", 32'(ready0), 32'd0);
        checkOutput("single busy after accept", 32'(busy0), 32'd1);
        checkOutput("single sen before transfer", 32'(sen0), 32'd0);
        tick();
        checkFrame("single", 8'hA5);
        checkOutput("single sen after", 32'(sen0), 32'd0);
        checkOutput("single busy after", 32'(busy0), 32'd0);
        checkOutput("single rx word", 32'(po0), 32'hA5);

        // Back-to-back 3C then C3 with no bubble
        applyStimulus(8'h3C, 1'b1);
        tick();
        applyStimulus('0, 1'b0);
        tick();
        for (int i = 0; i < 2 * W; i++) begin
            if (i == 0) applyStimulus(8'hC3, 1'b1);
            if (i == 1) begin
                applyStimulus('0, 1'b0);
                checkOutput("b2b ready while buffered", 32'(ready0), 32'd0);
            end
            if (i == W) checkOutput("b2b rx first", 32'(po0), 32'h3C);
            word = (i < W) ? 8'h3C : 8'hC3;
            checkOutput("b2b sen", 32'(sen0), 32'd1);
            checkOutput("b2b sout", 32'(sout0), 32'(word[i % W]));
            checkOutput("b2b frame_done", 32'(fd0), 32'((i == W - 1) || (i == 2 * W - 1)));
            tick();
        end
        checkOutput("b2b rx second", 32'(po0), 32'hC3);
        checkOutput("b2b sen after", 32'(sen0), 32'd0);

        // Backpressure: valid held high with 11, 22, 33
        bpWords[0] = 8'h11;
        bpWords[1] = 8'h22;
        bpWords[2] = 8'h33;
        idx     = 0;
        strobes = 0;
        applyStimulus(bpWords[0], 1'b1);
        for (int c = 0; c < 30; c++) begin
            accepted = valid0 && ready0;
            frameEnd = fd0;
            if (accepted) acceptLog.push_back(c);
            if (sen0) strobes++;
            tick();
            if (frameEnd) rxLog.push_back(po0);
            if (accepted) begin
                checkOutput("bp ready after accept", 32'(ready0), 32'd0);
                idx++;
                if (idx < 3) applyStimulus(bpWords[idx], 1'b1);
                else applyStimulus('0, 1'b0);
            end
        end
        checkOutput("bp accept count", 32'(acceptLog.size()), 32'd3);
        if (acceptLog.size() == 3) begin
            checkOutput("bp accept 1 cycle", 32'(acceptLog[0]), 32'd0);
            checkOutput("bp accept 2 cycle", 32'(acceptLog[1]), 32'd2);
            checkOutput("bp accept 3 cycle", 32'(acceptLog[2]), 32'd10);
        end
        checkOutput("bp frames received", 32'(rxLog.size()), 32'd3);
        if (rxLog.size() == 3) begin
            checkOutput("bp rx word 1", 32'(rxLog[0]), 32'h11);
            checkOutput("bp rx word 2", 32'(rxLog[1]), 32'h22);
            checkOutput("bp rx word 3", 32'(rxLog[2]), 32'h33);
        end
        checkOutput("bp strobe count", 32'(strobes), 32'd24);

        // Gap insertion on the GAP=2 instance: FF then 01
        for (int c = 0; c < 22; c++) begin
            if (c == 0) begin dinG = 8'hFF; validG = 1'b1; end
            if (c == 1) begin
                validG = 1'b0;
                checkOutput("gap ready while buffered", 32'(readyG), 32'd0);
            end
            if (c == 2) begin dinG = 8'h01; validG = 1'b1; end
            if (c == 3) validG = 1'b0;
            if (c == 10) checkOutput("gap rx first", 32'(poG), 32'hFF);
            if (c == 10 || c == 11) checkOutput("gap busy", 32'(busyG), 32'd1);
            if (c == 20) checkOutput("gap rx second", 32'(poG), 32'h01);
            expSen  = ((c >= 2) && (c <= 9)) || ((c >= 12) && (c <= 19));
            expSout = ((c >= 2) && (c <= 9)) || (c == 12);
            expFd   = (c == 9) || (c == 19);
            if (c >= 1) begin
                checkOutput("gap sen", 32'(senG), 32'(expSen));
                checkOutput("gap sout", 32'(soutG), 32'(expSout));
                checkOutput("gap frame_done", 32'(fdG), 32'(expFd));
            end
            tick();
        end

        // Async reset mid-frame with a word waiting in the buffer
        applyStimulus(8'h5A, 1'b1);
        tick();
        applyStimulus('0, 1'b0);
        tick();
        applyStimulus(8'hE7, 1'b1);
        tick();
        applyStimulus('0, 1'b0);
        tick();
        tick();
        checkOutput("rst pre sen", 32'(sen0), 32'd1);
        checkOutput("rst pre busy", 32'(busy0), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("rst async sout", 32'(sout0), 32'd0);
        checkOutput("rst async sen", 32'(sen0), 32'd0);
        checkOutput("rst async frame_done", 32'(fd0), 32'd0);
        checkOutput("rst async busy", 32'(busy0), 32'd0);
        checkOutput("rst async load_ready", 32'(ready0), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            checkOutput("rst discard sen", 32'(sen0), 32'd0);
            checkOutput("rst discard busy", 32'(busy0), 32'd0);
        end
        applyStimulus(8'h81, 1'b1);
        tick();
        applyStimulus('0, 1'b0);
        tick();
        checkFrame("post-reset", 8'h81);
        checkOutput("post-reset rx word", 32'(po0), 32'h81);
        checkOutput("post-reset busy", 32'(busy0), 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
